// File: rtl/biriscv_csr_hpm_pkg.sv
// Shared CSR addresses, mhpmevent field positions and decode helpers for the
// machine-mode performance-counter bank.
package biriscv_csr_hpm_pkg;

    localparam logic [3:0]  CSR_MCNT_PAGE      = 4'hB;   // mcycle/minstret/mhpmcounter B00..B9F
    localparam logic [3:0]  CSR_UCNT_PAGE      = 4'hC;   // user read-only shadows C00..C9F
    localparam int          CSR_HI_B           = 7;      // selects the upper half (B8x/C8x)
    localparam logic [11:0] CSR_MCOUNTINHIBIT  = 12'h320;
    localparam logic [11:0] CSR_MCOUNTEREN     = 12'h306;
    localparam logic [6:0]  CSR_MHPMEVENT_PAGE = 7'h19;  // 0x320..0x33F, events at 0x323+i

    localparam int HPMEVENT_SEL_MSB = 7;
    localparam int HPMEVENT_SEL_LSB = 0;
    localparam int HPMEVENT_OVIE_B  = 30;
    localparam int HPMEVENT_OF_B    = 31;

    localparam logic [4:0] IDX_CYCLE    = 5'd0;
    localparam logic [4:0] IDX_INSTRET  = 5'd2;
    localparam logic [4:0] IDX_HPM_BASE = 5'd3;

    typedef enum logic [2:0] {
        CSR_NONE,
        CSR_COUNTER,
        CSR_INHIBIT,
        CSR_COUNTEREN,
        CSR_EVENT
    } csr_kind_e;

    typedef struct packed {
        csr_kind_e  kind;
        logic       hi;
        logic       shadow;
        logic [4:0] idx;
    } csr_dec_t;

    // Bits of mcountinhibit/mcounteren that exist: 0, 2 and one per hpm counter.
    function automatic logic [31:0] impl_mask(input int num_hpm);
        logic [31:0] m;
        m = 32'h5;
        for (int i = 0; i < num_hpm; i++) m[3+i] = 1'b1;
        return m;
    endfunction

    // Counter slot s holds CSR index 0 (cycle), 2 (instret) or 3+ (hpm).
    function automatic logic [4:0] slot_idx(input int s);
        if (s == 0) return IDX_CYCLE;
        if (s == 1) return IDX_INSTRET;
        return 5'(s + 1);
    endfunction

    function automatic csr_dec_t csr_decode(input logic [11:0] addr, input int num_hpm);
        csr_dec_t d;
        logic     hpm_ok;
        d.kind   = CSR_NONE;
        d.hi     = addr[CSR_HI_B];
        d.shadow = (addr[11:8] == CSR_UCNT_PAGE);
        d.idx    = addr[4:0];
        hpm_ok   = (d.idx >= IDX_HPM_BASE) && (int'(d.idx) < int'(IDX_HPM_BASE) + num_hpm);
        if ((addr[11:8] == CSR_MCNT_PAGE || addr[11:8] == CSR_UCNT_PAGE) && addr[6:5] == 2'b00 &&
            (d.idx == IDX_CYCLE || d.idx == IDX_INSTRET || hpm_ok))
            d.kind = CSR_COUNTER;
        else if (addr == CSR_MCOUNTINHIBIT)
            d.kind = CSR_INHIBIT;
        else if (addr == CSR_MCOUNTEREN)
            d.kind = CSR_COUNTEREN;
        else if (addr[11:5] == CSR_MHPMEVENT_PAGE && hpm_ok)
            d.kind = CSR_EVENT;
        return d;
    endfunction

endpackage

// File: rtl/biriscv_hpm_counter.sv
// One COUNTER_W-bit performance counter with independent lo/hi software writes;
// a write to either half suppresses that cycle's increment entirely.
module biriscv_hpm_counter #(
    parameter int COUNTER_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lo_wen_i,
    input  logic                 hi_wen_i,
    input  logic [31:0]          wdata_i,
    input  logic [1:0]           inc_i,
    input  logic                 inhibit_i,
    output logic [COUNTER_W-1:0] count_o,
    output logic                 wrap_o
);
    localparam int HI_W = COUNTER_W - 32;

    logic [COUNTER_W-1:0] count_q, count_d;
    logic [COUNTER_W:0]   sum;
    logic                 inc_en;

    assign inc_en = !inhibit_i && !lo_wen_i && !hi_wen_i && (inc_i != 2'd0);
    assign sum    = {1'b0, count_q} + (COUNTER_W+1)'(inc_i);
    assign wrap_o = inc_en && sum[COUNTER_W];

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (lo_wen_i) count_d[31:0] = wdata_i;
        if (hi_wen_i) count_d[COUNTER_W-1:32] = wdata_i[HI_W-1:0];
        if (inc_en)   count_d = sum[COUNTER_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/biriscv_csr_hpm.sv
// Machine-mode performance-counter CSR bank: mcycle, minstret, NUM_HPM event
// counters with overflow flags, inhibit/enable masks and a registered overflow IRQ.
module biriscv_csr_hpm
    import biriscv_csr_hpm_pkg::*;
#(
    parameter int NUM_HPM    = 4,
    parameter int NUM_EVENTS = 16,
    parameter int COUNTER_W  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            priv_i,
    input  logic [11:0]           csr_raddr_i,
    output logic [31:0]           csr_rdata_o,
    output logic                  csr_hit_o,
    output logic                  csr_fault_o,
    input  logic                  csr_wen_i,
    input  logic [11:0]           csr_waddr_i,
    input  logic [31:0]           csr_wdata_i,
    input  logic [1:0]            retire_cnt_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    output logic                  ovf_irq_o
);
    localparam int          NUM_CNT   = NUM_HPM + 2;
    localparam int          NH        = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] IMPL_MASK = impl_mask(NUM_HPM);

    csr_dec_t rdec, wdec;
    assign rdec = csr_decode(csr_raddr_i, NUM_HPM);
    assign wdec = csr_decode(csr_waddr_i, NUM_HPM);

    logic [31:0]                         inhibit_q, counteren_q;
    logic [NH-1:0][7:0]                  sel_q;
    logic [NH-1:0]                       ovie_q, of_q, ev_hit;
    logic                                ovf_irq_q;
    logic [NUM_CNT-1:0][COUNTER_W-1:0]   count;
    logic [NUM_CNT-1:0][1:0]             inc;
    logic [NUM_CNT-1:0]                  wrap;

    always_comb begin
        ev_hit = '0;
        for (int i = 0; i < NUM_HPM; i++)
            for (int e = 0; e < NUM_EVENTS; e++)
                if (sel_q[i] == 8'(e + 1) && event_i[e]) ev_hit[i] = 1'b1;
    end

    for (genvar s = 0; s < NUM_CNT; s++) begin : g_cnt
        localparam logic [4:0] IDX = slot_idx(s);
        logic wsel;

        if (s == 0)      begin : g_cyc  assign inc[s] = 2'd1; end
        else if (s == 1) begin : g_ret  assign inc[s] = (retire_cnt_i == 2'd3) ? 2'd2 : retire_cnt_i; end
        else             begin : g_hpm  assign inc[s] = {1'b0, ev_hit[s-2]}; end

        assign wsel = csr_wen_i && (wdec.kind == CSR_COUNTER) && !wdec.shadow && (wdec.idx == IDX);

        biriscv_hpm_counter #(.COUNTER_W(COUNTER_W)) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .lo_wen_i  (wsel && !wdec.hi),
            .hi_wen_i  (wsel && wdec.hi),
            .wdata_i   (csr_wdata_i),
            .inc_i     (inc[s]),
            .inhibit_i (inhibit_q[IDX]),
            .count_o   (count[s]),
            .wrap_o    (wrap[s])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inhibit_q   <= '0;
            counteren_q <= '0;
            sel_q       <= '0;
            ovie_q      <= '0;
            of_q        <= '0;
            ovf_irq_q   <= 1'b0;
        end else begin
            if (csr_wen_i && wdec.kind == CSR_INHIBIT)   inhibit_q   <= csr_wdata_i & IMPL_MASK;
            if (csr_wen_i && wdec.kind == CSR_COUNTEREN) counteren_q <= csr_wdata_i & IMPL_MASK;
            // A software write to mhpmevent overrides a same-cycle wrap.
            for (int i = 0; i < NUM_HPM; i++) begin
                if (csr_wen_i && wdec.kind == CSR_EVENT && wdec.idx == 5'(int'(IDX_HPM_BASE) + i)) begin
                    sel_q[i]  <= csr_wdata_i[HPMEVENT_SEL_MSB:HPMEVENT_SEL_LSB];
                    ovie_q[i] <= csr_wdata_i[HPMEVENT_OVIE_B];
                    of_q[i]   <= csr_wdata_i[HPMEVENT_OF_B];
                end else if (wrap[2+i]) begin
                    of_q[i] <= 1'b1;
                end
            end
            ovf_irq_q <= |(of_q & ovie_q);
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        case (rdec.kind)
            CSR_COUNTER: begin
                for (int s = 0; s < NUM_CNT; s++)
                    if (slot_idx(s) == rdec.idx)
                        csr_rdata_o = rdec.hi ? 32'(count[s][COUNTER_W-1:32]) : count[s][31:0];
            end
            CSR_INHIBIT:   csr_rdata_o = inhibit_q;
            CSR_COUNTEREN: csr_rdata_o = counteren_q;
            CSR_EVENT: begin
                for (int i = 0; i < NUM_HPM; i++)
                    if (rdec.idx == 5'(int'(IDX_HPM_BASE) + i)) begin
                        csr_rdata_o[HPMEVENT_SEL_MSB:HPMEVENT_SEL_LSB] = sel_q[i];
                        csr_rdata_o[HPMEVENT_OVIE_B]                   = ovie_q[i];
                        csr_rdata_o[HPMEVENT_OF_B]                     = of_q[i];
                    end
            end
            default: ;
        endcase
    end

    assign csr_hit_o   = (rdec.kind != CSR_NONE);
    assign csr_fault_o = (rdec.kind == CSR_COUNTER) && rdec.shadow && (priv_i != 2'd3) &&
                         !counteren_q[rdec.idx];
    assign ovf_irq_o   = ovf_irq_q;

endmodule

// File: doc/biriscv_csr_hpm.md
Name: biriscv_csr_hpm

Overview:
Parametrised machine-mode performance-counter CSR bank for the dual-issue biRISC-V core.
- Provides mcycle, minstret and NUM_HPM programmable mhpmcounters, each COUNTER_W bits wide and split into lo/hi CSRs.
- Provides mhpmevent selectors, mcountinhibit, mcounteren, per-counter overflow flags and an overflow interrupt.
- Sits beside the CSR regfile. Reads and the access-fault check are served at issue (E1); writes are committed from writeback.

Parameters:
NUM_HPM, 4, number of mhpmcounter3..(3+NUM_HPM-1); legal range 0..29.
NUM_EVENTS, 16, width of event_i; legal range 1..255.
COUNTER_W, 64, implemented counter width; legal range 33..64. Hi-CSR bits above COUNTER_W-32 read 0 and ignore writes.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
priv_i  in  2  current privilege level (3 = machine)
csr_raddr_i  in  12  issue-stage read address
csr_rdata_o  out  32  read data; combinational; 0 on miss
csr_hit_o  out  1  raddr decodes to a CSR owned by this block
csr_fault_o  out  1  user-shadow read denied
csr_wen_i  in  1  writeback write strobe
csr_waddr_i  in  12  writeback address
csr_wdata_i  in  32  writeback data
retire_cnt_i  in  2  instructions retired this cycle, 0..2; value 3 is treated as 2
event_i  in  NUM_EVENTS  one-cycle event pulses
ovf_irq_o  out  1  overflow interrupt, registered

Behaviour:
- Reset: all counters 0, mhpmevent 0, mcountinhibit 0, mcounteren 0, ovf_irq_o 0.
- Address map:
  - mcycle B00/B80, minstret B02/B82, mhpmcounter(3+i) B03+i/B83+i.
  - mcountinhibit 320, mhpmevent(3+i) 323+i, mcounteren 306.
  - User shadows C00/C80, C02/C82, C03+i/C83+i.
  - Addresses for counters with i >= NUM_HPM give csr_hit_o=0.
- Shadow access:
  - Shadows are read-only.
  - csr_fault_o=1 when the shadow is read with priv_i<3 and the mcounteren bit for that counter index is 0.
  - csr_rdata_o still returns the value; the fault is acted on by the CSR unit.
- Per-cycle increments:
  - mcycle +1 every cycle.
  - minstret +retire_cnt_i.
  - hpm i +1 when its event field sel (mhpmevent[7:0]) is nonzero and event_i[sel-1]=1.
  - sel=0 or sel>NUM_EVENTS counts nothing.
  - A counter whose mcountinhibit bit is set does not increment.
- Inhibit/enable register widths:
  - mcountinhibit and mcounteren implement bits 0, 2 and 3..3+NUM_HPM-1 only. All other bits, including bit 1, read 0 and are not writable.
- mhpmevent fields:
  - [7:0] event select.
  - [30] OVIE, interrupt enable.
  - [31] OF, overflow flag.
  - All other bits read 0.
- Overflow:
  - When an hpm counter wraps from all-ones to 0 through an increment, OF is set in the same clock edge.
  - OF is sticky and is cleared only by a software write.
  - A software write of OF=1 also sets it.
- Write/increment collision:
  - A CSR write to a counter's lo or hi half wins in that cycle. The whole counter skips its increment that cycle, and no carry passes into the unwritten half.
  - A write to mhpmevent in the same cycle as a wrap: the written OF value wins.
- Write latency:
  - Writes take effect at the next clock edge; the read of that CSR in the following cycle returns the new value.
  - Reading in the same cycle as the write returns the old value. The core already serialises this hazard.
- Interrupt: ovf_irq_o is registered, ovf_irq_o <= OR over i of (OF_i & OVIE_i); it has one cycle of latency from the flag setting.
- Width: counters are modular at COUNTER_W. mcycle and minstret also wrap, but have no overflow flag.
- Reset mid-count: asynchronous clear of all state; the first increment happens at the first edge after reset is released.

Decomposition:
- Add to biriscv_defs.v:
  - CSR address defines (mhpmcounter/mhpmevent/mcountinhibit/mcounteren bases and their hi/shadow offsets).
  - Field positions HPMEVENT_SEL_R, HPMEVENT_OVIE_B, HPMEVENT_OF_B.
- Sub-module biriscv_hpm_counter:
  - One COUNTER_W counter with lo/hi write ports, an increment amount input (0..2), an inhibit input and a wrap pulse output.
  - Instantiated NUM_HPM+2 times.

Test Plan:
- Reset, idle 10 cycles → mcycle lo reads 10 ±1 (fixed by the read cycle), minstret 0, ovf_irq_o 0.
- retire_cnt_i=2 for 5 cycles, then 1 for 3 cycles → minstret=13; mcountinhibit=0x4 for 4 of those cycles → the count stops over those cycles.
- mhpmevent3=0x4000_0003; write mhpmcounter3 hi/lo to 0xFFFFFFFF_FFFFFFFE; pulse event_i[2] twice → counter=0, OF=1 on the second edge, ovf_irq_o=1 one cycle later.
- Write mhpmevent3=0x0000_0003 → OF and OVIE cleared, ovf_irq_o=0 next cycle; the counter keeps counting.
- Write mcycle lo=0x100 in the same cycle as an increment with lo=0xFFFFFFFF → lo=0x100, hi unchanged.
- Read C03 with priv_i=0: mcounteren=0 → csr_fault_o=1, csr_hit_o=1; mcounteren=0x8 → csr_fault_o=0. Read B0F with NUM_HPM=4 → csr_hit_o=0, csr_rdata_o=0.
